mt_seed_init: RTL and testbench
===============================

Name: mt_seed_init

Overview:
- Seeding stage directly upstream of the MT19937 dual-port state SRAM.
- On a start request, it fills all N state words using the standard MT19937 init recurrence, through the SRAM write port (wr/Addr1/Di).
- It signals completion so the twist/temper engine may begin reading.
- It owns the SRAM write port only while busy; the consumer must not drive the SRAM while busy=1.

Parameters:
- N, 624, number of state words; sets the address width $clog2(N).
- MULT, 32'd1812433253, init recurrence multiplier.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to seed; sampled only in IDLE.
- seed  input  32  seed value; captured on the cycle start is accepted.
- busy  output  1  high from the cycle after acceptance until done is asserted.
- done  output  1  one-cycle pulse after the final word is written.
- sram_wr  output  1  SRAM write enable.
- sram_addr  output  $clog2(N)  SRAM write address.
- sram_di  output  32  SRAM write data.

Behaviour:
- Reset (nrst=0, asynchronous):
  - State goes to IDLE.
  - busy, done, sram_wr, sram_addr and sram_di all go to 0.
  - The index counter and prev register go to 0.
- States: IDLE, WRITE, DONE (plus CALC when MT_SEED_PIPE_EN is defined).
- IDLE:
  - start=1 captures seed into prev, sets the index to 0 and moves to WRITE.
  - start=0 stays in IDLE.
- WRITE, at index i:
  - Drives sram_wr=1, sram_addr=i, sram_di=mt[i].
  - mt[0] = seed.
  - mt[i] = (MULT * (mt[i-1] ^ (mt[i-1] >> 30)) + i) mod 2^32, with i zero-extended to 32 bits.
  - All products are truncated to 32 bits.
  - prev is updated to mt[i] on the same edge.
- Sequencing:
  - If i == N-1, move to DONE; otherwise i increments and the FSM stays in WRITE.
  - Base build: exactly one word per cycle.
  - The first write is in the cycle after start is accepted; the last write is N cycles after acceptance.
- DONE:
  - sram_wr=0, done=1 for exactly one cycle, busy=0.
  - Returns to IDLE.
- Outputs are registered: sram_wr, sram_addr and sram_di are flops, not combinational from state.
- sram_wr=0 in every state other than WRITE.
  - sram_addr and sram_di hold their last value when sram_wr=0.
- The recurrence uses only the internal prev register; there is no readback from the SRAM.
- start while busy=1 or in DONE: ignored, with no restart and no queuing.
- start in the same cycle done is asserted: ignored. It is accepted on the next cycle if still high.
- A change on seed after acceptance has no effect.
- Reset mid-operation:
  - Aborts immediately; done is not pulsed.
  - SRAM contents are partial and undefined; a new start is required.
- Index wrap: the counter never exceeds N-1. Address N is never driven.

Optional Feature:
- Macro: MT_SEED_PIPE_EN.
- Defined:
  - The multiply result is registered in a CALC state between writes, to relieve the 32x32 multiplier timing path.
  - Flow: IDLE -> WRITE(0) -> CALC -> WRITE(1) -> CALC -> ... -> WRITE(N-1) -> DONE.
  - sram_wr is high on alternate cycles.
  - The last write is 2N-1 cycles after acceptance.
  - busy, done, values and addresses are identical to the base build.
- Undefined:
  - No CALC state; the combinational multiply path is used.
  - One word per cycle, as above.

Test Plan:
- Reset values: hold nrst=0, then release -> busy=0, done=0, sram_wr=0, sram_addr=0, sram_di=0; idle for 10 cycles with no writes.
- Standard seed: seed=5489, pulse start -> first write addr 0 data 5489; second write addr 1 data 1301868182; exactly N writes to addresses 0..N-1 in order; done pulses once, 1 cycle after the write to N-1 (N+1 cycles after acceptance in the base build).
- Zero seed: seed=0 -> addr 0 data 0; addr 1 data 1; addr 2 data 1812433255. Compare all N words against a software MT19937 init model.
- Ignored requests: hold start=1 continuously with seed=5489 in the first cycle; change seed to 1 after acceptance -> stream still matches 5489. A second run starts the cycle after done; no extra writes occur before then.
- Mid-run reset: assert nrst=0 asynchronously between clock edges at index 100 -> sram_wr and busy drop without waiting for a clock edge; no done pulse. A subsequent start=1 with seed=7 restarts at addr 0 with data 7.
- MT_SEED_PIPE_EN defined, seed=5489 -> same address/data sequence; sram_wr alternates 1,0; done occurs 2N cycles after acceptance.

Source files
------------

// File: rtl/mt_seed_init.sv
// mt_seed_init: fills the MT19937 state SRAM with the standard init recurrence
//   mt[0] = seed
//   mt[i] = MULT * (mt[i-1] ^ (mt[i-1] >> 30)) + i   (mod 2^32)
// One word is written per cycle through the SRAM write port (sram_wr/addr/di).
// Optional build macro: MT_SEED_PIPE_EN adds a CALC state that registers the
// 32x32 product between writes, so words are written on alternate cycles.
// dbg_state exposes the FSM state for observation.
module mt_seed_init #(
  parameter int          N    = 624,
  parameter logic [31:0] MULT = 32'd1812433253
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_wr,
  output logic [$clog2(N)-1:0] sram_addr,
  output logic [31:0]          sram_di,
  output logic [1:0]           dbg_state
);

  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // Handshake: start is a request that is accepted only when the FSM is IDLE
  // (busy=0 and done=0); a request seen while busy or during the done pulse is
  // dropped, never queued. busy stays high from the cycle after acceptance
  // until the single-cycle done pulse, and the SRAM write port belongs to this
  // block only while busy is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
`ifdef MT_SEED_PIPE_EN
    , CALC = 2'd3
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   prev_q, prev_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   di_q, di_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef MT_SEED_PIPE_EN
  logic [31:0]   mult_q, mult_d;
`endif

  logic [AW-1:0] idx_nx;
  logic [31:0]   mix;
  logic [31:0]   word_nx;

  // Next word of the recurrence, derived only from the internal prev register.
  always_comb begin
    idx_nx = idx_q + 1'b1;
    mix    = prev_q ^ (prev_q >> 30);
`ifdef MT_SEED_PIPE_EN
    word_nx = mult_q + {{(32-AW){1'b0}}, idx_nx};
`else
    word_nx = MULT * mix + {{(32-AW){1'b0}}, idx_nx};
`endif
  end

  // Next-state and registered-output logic; outputs are precomputed so the
  // SRAM port is driven straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    di_d    = di_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MT_SEED_PIPE_EN
    mult_d  = mult_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          idx_d   = '0;
          prev_d  = seed;
          wr_d    = 1'b1;
          addr_d  = '0;
          di_d    = seed;
          busy_d  = 1'b1;
        end
      end
      WRITE: begin
        if (idx_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
`ifdef MT_SEED_PIPE_EN
          state_d = CALC;
          mult_d  = MULT * mix;
`else
          idx_d   = idx_nx;
          prev_d  = word_nx;
          wr_d    = 1'b1;
          addr_d  = idx_nx;
          di_d    = word_nx;
`endif
        end
      end
`ifdef MT_SEED_PIPE_EN
      CALC: begin
        state_d = WRITE;
        idx_d   = idx_nx;
        prev_d  = word_nx;
        wr_d    = 1'b1;
        addr_d  = idx_nx;
        di_d    = word_nx;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      prev_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MT_SEED_PIPE_EN
      mult_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MT_SEED_PIPE_EN
      mult_q  <= mult_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_wr   = wr_q;
  assign sram_addr = addr_q;
  assign sram_di   = di_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mt_seed_init.sv
// tb_mt_seed_init: randomized and directed checks of mt_seed_init against a
// software MT19937 init model (64-bit arithmetic, masked to 32 bits).
module tb_mt_seed_init;

  localparam int N  = 624;
  localparam int AW = $clog2(N);
`ifdef MT_SEED_PIPE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [31:0]   seed;
  logic          busy;
  logic          done;
  logic          sram_wr;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_di;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mt_seed_init #(.N(N), .MULT(32'd1812433253)) dut (
    .clk(clk), .nrst(nrst), .start(start), .seed(seed),
    .busy(busy), .done(done), .sram_wr(sram_wr),
    .sram_addr(sram_addr), .sram_di(sram_di), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [AW+31:0]  exp_q[$];
  logic [AW+31:0]  obs_q[$];
  int              obs_cyc[$];
  int              done_cyc;
  int              busy_bad;

  // Reference model: whole MT19937 init table, pushed as {addr, data}.
  task automatic build_ref(input logic [31:0] s);
    longint unsigned p;
    logic [AW-1:0]   a;
    exp_q.delete();
    p = 64'(s);
    exp_q.push_back({{AW{1'b0}}, s});
    for (int i = 1; i < N; i++) begin
      p = ((64'd1812433253 * (p ^ (p >> 30))) + 64'(i)) & 64'hFFFF_FFFF;
      a = AW'(i);
      exp_q.push_back({a, p[31:0]});
    end
  endtask

  // Driver: pulses (or holds) start and records every write until done.
  task automatic capture(input logic [31:0] s, input bit hold, input bit chg,
                         input int max_cyc);
    obs_q.delete();
    obs_cyc.delete();
    done_cyc = -1;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (sram_wr) begin
        obs_q.push_back({sram_addr, sram_di});
        obs_cyc.push_back(c);
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (done_cyc < 0 && busy !== 1'b1) busy_bad++;
      if (done_cyc == c && busy !== 1'b0) busy_bad++;
      if (!hold) start = 1'b0;
      if (chg) seed = 32'd1;
      if (done_cyc >= 0) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int extra;
    nrst  = 1'b0;
    start = 1'b0;
    seed  = 32'd0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, sram_wr, sram_addr, sram_di} !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b wr=%b addr=%0d di=%0h, want all 0",
               busy, done, sram_wr, sram_addr, sram_di);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (sram_wr !== 1'b0 || done !== 1'b0 || busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d active cycles while idle, want 0", extra);
    end
  endtask

  task automatic test_full_run(input logic [31:0] s, input string name);
    int bad_data, bad_time, n;
    build_ref(s);
    capture(s, 1'b0, 1'b0, 3 * N);
    checks++;
    if (obs_q.size() != N) begin
      errors++;
      $display("FAIL %s write_count: got %0d, want %0d", name, obs_q.size(), N);
    end
    n = (obs_q.size() < N) ? obs_q.size() : N;
    bad_data = 0;
    bad_time = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        bad_data++;
        if (bad_data <= 8)
          $display("FAIL %s word %0d: got addr=%0d data=%0h, want addr=%0d data=%0h",
                   name, k, obs_q[k][AW+31:32], obs_q[k][31:0],
                   exp_q[k][AW+31:32], exp_q[k][31:0]);
      end
      if (obs_cyc[k] != STEP * k + 1) bad_time++;
    end
    checks++;
    if (bad_time != 0) begin
      errors++;
      $display("FAIL %s write_timing: %0d writes off-cycle, want 0", name, bad_time);
    end
    checks++;
    if (done_cyc != STEP * (N - 1) + 2) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d, want %0d", name, done_cyc, STEP * (N - 1) + 2);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_window: %0d bad cycles, want 0", name, busy_bad);
    end
    @(negedge clk);
    checks++;
    if ({done, sram_wr, busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_done: got done=%b wr=%b busy=%b, want 000",
               name, done, sram_wr, busy);
    end
  endtask

  task automatic test_standard_seed();
    test_full_run(32'd5489, "std");
    checks++;
    if (obs_q.size() < 2 || obs_q[0] !== {{AW{1'b0}}, 32'd5489}) begin
      errors++;
      $display("FAIL std_word0: got %0h, want addr 0 data 5489", obs_q.size() > 0 ? obs_q[0] : '0);
    end
    checks++;
    if (obs_q.size() < 2 || obs_q[1] !== {AW'(1), 32'd1301868182}) begin
      errors++;
      $display("FAIL std_word1: got %0h, want addr 1 data 1301868182", obs_q.size() > 1 ? obs_q[1] : '0);
    end
  endtask

  task automatic test_zero_seed();
    test_full_run(32'd0, "zero");
    checks++;
    if (obs_q.size() < 3 || obs_q[0][31:0] !== 32'd0 || obs_q[1][31:0] !== 32'd1 ||
        obs_q[2][31:0] !== 32'd1812433255) begin
      errors++;
      $display("FAIL zero_first3: got %0h/%0h/%0h, want 0/1/1812433255",
               obs_q.size() > 2 ? obs_q[0][31:0] : 32'hx,
               obs_q.size() > 2 ? obs_q[1][31:0] : 32'hx,
               obs_q.size() > 2 ? obs_q[2][31:0] : 32'hx);
    end
  endtask

  task automatic test_random_seeds();
    for (int r = 0; r < 2; r++) test_full_run($urandom, "rand");
  endtask

  task automatic test_ignored_requests();
    int bad;
    int got_done;
    build_ref(32'd5489);
    capture(32'd5489, 1'b1, 1'b1, 3 * N);
    bad = 0;
    for (int k = 0; k < N; k++)
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != N) begin
      errors++;
      $display("FAIL hold_stream: %0d bad words, %0d writes, want 0 bad and %0d writes",
               bad, obs_q.size(), N);
    end
    checks++;
    if (done_cyc != STEP * (N - 1) + 2) begin
      errors++;
      $display("FAIL hold_done_cycle: got %0d, want %0d", done_cyc, STEP * (N - 1) + 2);
    end
    @(negedge clk);
    checks++;
    if ({sram_wr, done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL hold_gap: got wr=%b done=%b busy=%b, want 000", sram_wr, done, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({sram_wr, busy, sram_addr, sram_di} !== {1'b1, 1'b1, {AW{1'b0}}, 32'd1}) begin
      errors++;
      $display("FAIL hold_restart: got wr=%b busy=%b addr=%0d di=%0h, want 1 1 0 1",
               sram_wr, busy, sram_addr, sram_di);
    end
    got_done = 0;
    for (int c = 0; c < 3 * N && got_done == 0; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    checks++;
    if (got_done != 1) begin
      errors++;
      $display("FAIL hold_second_done: got %0d, want 1", got_done);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int found, seen_done;
    found = 0;
    @(negedge clk);
    start = 1'b1;
    seed  = $urandom;
    for (int c = 0; c < 3 * N && found == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sram_wr && sram_addr == AW'(100)) found = 1;
    end
    checks++;
    if (found != 1) begin
      errors++;
      $display("FAIL midrst_reach100: got %0d, want 1", found);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({sram_wr, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async: got wr=%b busy=%b done=%b, want 000", sram_wr, busy, done);
    end
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || sram_wr) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d active cycles, want 0", seen_done);
    end
    test_full_run(32'd7, "seed7");
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== {{AW{1'b0}}, 32'd7}) begin
      errors++;
      $display("FAIL midrst_restart: got %0h, want addr 0 data 7", obs_q.size() > 0 ? obs_q[0] : '0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_standard_seed();
    test_zero_seed();
    test_random_seeds();
    test_ignored_requests();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
